// File: rtl/signal_safety_monitor.sv
// Registered lamp pass-through with fault filtering and a flashing-red failsafe for the 4-approach controller.
// Build macro YELLOW_CHECK_EN enables the green->red yellow-skip check (fault code 4).
module signal_safety_monitor #(
    parameter int FILTER_CYCLES = 4,
    parameter int WDOG_TICKS    = 15,
    parameter int ALLRED_TICKS  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [2:0] l_in,
    input  logic [2:0] r_in,
    input  logic [2:0] s_in,
    input  logic [2:0] b_in,
    input  logic       clr_fault,
    output logic [2:0] l,
    output logic [2:0] r,
    output logic [2:0] s,
    output logic [2:0] b,
    output logic       fault,
    output logic [2:0] fault_code
);
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] DARK   = 3'b000;
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int WW = $clog2(WDOG_TICKS + 1);
    localparam int TW = $clog2(ALLRED_TICKS + 1);

    typedef enum logic [1:0] {ST_ALLRED, ST_NORMAL, ST_FLASH} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [FW-1:0] conf_cnt_q, conf_cnt_d;
    logic [FW-1:0] inval_cnt_q, inval_cnt_d;
    logic [11:0]   prev_in_q, prev_in_d;
    logic [11:0]   lamps_q, lamps_d;
    logic          flash_q, flash_d;
    logic          fault_q, fault_d;
    logic [2:0]    code_q, code_d;

    logic [11:0] lamps_in;
    logic [3:0]  greens;
    logic        conflict_raw, invalid_raw, skip_raw, decl_skip;

    assign lamps_in = {l_in, r_in, s_in, b_in};

    function automatic logic [FW-1:0] persist(input logic cond, input logic [FW-1:0] cnt);
        return !cond ? '0 : ((cnt == FW'(FILTER_CYCLES)) ? cnt : cnt + 1'b1);
    endfunction

    always_comb begin
        greens      = '0;
        invalid_raw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            greens[i] = (lamps_in[3*i +: 3] == GREEN);
            if (lamps_in[3*i +: 3] != GREEN && lamps_in[3*i +: 3] != YELLOW &&
                lamps_in[3*i +: 3] != RED)
                invalid_raw = 1'b1;
        end
        conflict_raw = ($countones(greens) > 1);
    end

`ifdef YELLOW_CHECK_EN
    // A skip stays flagged while the approach keeps holding the red it jumped to.
    logic [3:0]    skip_q, skip_d;
    logic [FW-1:0] skip_cnt_q, skip_cnt_d;

    always_comb begin
        for (int i = 0; i < 4; i++)
            skip_d[i] = (lamps_in[3*i +: 3] == RED) &&
                        ((prev_in_q[3*i +: 3] == GREEN) || skip_q[i]);
        skip_raw   = |skip_d;
        skip_cnt_d = persist(skip_raw, skip_cnt_q);
        decl_skip  = (skip_cnt_d == FW'(FILTER_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_q     <= '0;
            skip_cnt_q <= '0;
        end else begin
            skip_q     <= skip_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end
`else
    assign skip_raw  = 1'b0;
    assign decl_skip = 1'b0;
`endif

    // NOTE: every variable gets a default at the top of the block so no path infers a latch.
    always_comb begin
        logic decl_conf, decl_inval, decl_wdog;
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        flash_d     = flash_q;
        code_d      = code_q;
        prev_in_d   = lamps_in;
        conf_cnt_d  = persist(conflict_raw, conf_cnt_q);
        inval_cnt_d = persist(invalid_raw, inval_cnt_q);

        if (lamps_in != prev_in_q)
            wdog_d = '0;
        else if (tick && wdog_q != WW'(WDOG_TICKS))
            wdog_d = wdog_q + 1'b1;
        else
            wdog_d = wdog_q;

        decl_conf  = (conf_cnt_d == FW'(FILTER_CYCLES));
        decl_inval = (inval_cnt_d == FW'(FILTER_CYCLES));
        decl_wdog  = (wdog_d == WW'(WDOG_TICKS));

        case (state_q)
            ST_ALLRED, ST_NORMAL: begin
                if (decl_conf || decl_inval || decl_wdog || decl_skip) begin
                    state_d    = ST_FLASH;
                    flash_d    = 1'b1;
                    tick_cnt_d = '0;
                    code_d     = decl_conf ? 3'd1 : decl_inval ? 3'd2 : decl_wdog ? 3'd3 : 3'd4;
                end else if (state_q == ST_ALLRED && tick) begin
                    if (tick_cnt_q == TW'(ALLRED_TICKS - 1)) begin
                        state_d    = ST_NORMAL;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            ST_FLASH: begin
                // Clearing is refused while any filtered condition is still raw-true.
                if (clr_fault && !conflict_raw && !invalid_raw && !skip_raw) begin
                    state_d    = ST_ALLRED;
                    code_d     = 3'd0;
                    wdog_d     = '0;
                    tick_cnt_d = '0;
                end else if (tick) begin
                    flash_d = ~flash_q;
                end
            end
            default: state_d = ST_ALLRED;
        endcase

        fault_d = (state_d == ST_FLASH);
        case (state_d)
            ST_NORMAL: lamps_d = lamps_in;
            ST_FLASH:  lamps_d = {4{flash_d ? RED : DARK}};
            default:   lamps_d = {4{RED}};
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ALLRED;
            tick_cnt_q  <= '0;
            wdog_q      <= '0;
            conf_cnt_q  <= '0;
            inval_cnt_q <= '0;
            prev_in_q   <= {4{RED}};
            lamps_q     <= {4{RED}};
            flash_q     <= 1'b0;
            fault_q     <= 1'b0;
            code_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            wdog_q      <= wdog_d;
            conf_cnt_q  <= conf_cnt_d;
            inval_cnt_q <= inval_cnt_d;
            prev_in_q   <= prev_in_d;
            lamps_q     <= lamps_d;
            flash_q     <= flash_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
        end
    end

    assign {l, r, s, b} = lamps_q;
    assign fault        = fault_q;
    assign fault_code   = code_q;
endmodule

// File: tb/tb_signal_safety_monitor.sv
// Randomized and directed bench for signal_safety_monitor checked against a history-based reference model.
// Honors YELLOW_CHECK_EN the same way the design does.
module tb_signal_safety_monitor;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;
    localparam int FILT  = 4;
    localparam int WDOG  = 15;
    localparam int ARED  = 2;

    logic       clk = 1'b0;
    logic       rst, tick, clr_fault;
    logic [2:0] l_in, r_in, s_in, b_in;
    logic [2:0] l, r, s, b, fault_code;
    logic       fault;

    always #5 clk = ~clk;

    signal_safety_monitor dut (
        .clk(clk), .rst(rst), .tick(tick),
        .l_in(l_in), .r_in(r_in), .s_in(s_in), .b_in(b_in),
        .clr_fault(clr_fault),
        .l(l), .r(r), .s(s), .b(b),
        .fault(fault), .fault_code(fault_code)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_ALLRED, M_NORMAL, M_FLASH} mode_t;
    mode_t       m_mode;
    int          m_red_ticks, m_still_ticks, m_code;
    bit          m_phase;
    logic [11:0] hist[$];
    bit          c1_hist[$], c2_hist[$], c4_hist[$];
    logic [11:0] e_lamps;
    bit          e_fault;

    function automatic bit is_conflict(input logic [11:0] p);
        int g = 0;
        for (int i = 0; i < 4; i++) if (p[3*i +: 3] == G) g++;
        return g > 1;
    endfunction

    function automatic bit is_invalid(input logic [11:0] p);
        for (int i = 0; i < 4; i++)
            if (!(p[3*i +: 3] inside {G, Y, R})) return 1'b1;
        return 1'b0;
    endfunction

    // An approach now red whose unbroken red run was entered straight from green.
    function automatic bit is_skip();
        logic [11:0] cur;
        logic [11:0] past;
        cur = hist[hist.size()-1];
        for (int i = 0; i < 4; i++) begin
            if (cur[3*i +: 3] == R) begin
                for (int j = hist.size() - 2; j >= 0; j--) begin
                    past = hist[j];
                    if (past[3*i +: 3] == R) continue;
                    if (past[3*i +: 3] == G) return 1'b1;
                    break;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic bit held(input bit q[$]);
        if (q.size() < FILT) return 1'b0;
        for (int i = q.size() - FILT; i < q.size(); i++) if (!q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input logic [11:0] pin, input bit tk, input bit clr, input bit rs);
        bit raw1, raw2, raw4, changed, d1, d2, d3, d4;
        if (rs) begin
            m_mode = M_ALLRED; m_red_ticks = 0; m_still_ticks = 0; m_code = 0; m_phase = 0;
            hist = {12'h924};
            c1_hist = {}; c2_hist = {}; c4_hist = {};
        end else begin
            changed = (pin != hist[hist.size()-1]);
            hist.push_back(pin);
            raw1 = is_conflict(pin);
            raw2 = is_invalid(pin);
`ifdef YELLOW_CHECK_EN
            raw4 = is_skip();
`else
            raw4 = 1'b0;
`endif
            c1_hist.push_back(raw1); c2_hist.push_back(raw2); c4_hist.push_back(raw4);
            if (c1_hist.size() > FILT) begin
                void'(c1_hist.pop_front()); void'(c2_hist.pop_front()); void'(c4_hist.pop_front());
            end
            if (changed) m_still_ticks = 0;
            else if (tk) m_still_ticks++;
            d1 = held(c1_hist); d2 = held(c2_hist); d4 = held(c4_hist);
            d3 = (m_still_ticks >= WDOG);
            if (m_mode != M_FLASH && (d1 || d2 || d3 || d4)) begin
                m_mode = M_FLASH; m_phase = 1; m_red_ticks = 0;
                m_code = d1 ? 1 : d2 ? 2 : d3 ? 3 : 4;
            end else if (m_mode == M_ALLRED) begin
                if (tk) begin
                    m_red_ticks++;
                    if (m_red_ticks == ARED) begin m_mode = M_NORMAL; m_red_ticks = 0; end
                end
            end else if (m_mode == M_FLASH) begin
                if (clr && !raw1 && !raw2 && !raw4) begin
                    m_mode = M_ALLRED; m_code = 0; m_still_ticks = 0; m_red_ticks = 0;
                end else if (tk) m_phase = !m_phase;
            end
        end
        e_fault = (m_mode == M_FLASH);
        case (m_mode)
            M_NORMAL: e_lamps = pin;
            M_FLASH:  e_lamps = m_phase ? {R, R, R, R} : 12'h000;
            default:  e_lamps = {R, R, R, R};
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit tk, input bit clr, input bit rs);
        @(negedge clk);
        tick = tk; clr_fault = clr; rst = rs;
        model_step({l_in, r_in, s_in, b_in}, tk, clr, rs);
        @(posedge clk);
        #1;
        check("l", l, e_lamps[11:9]);
        check("r", r, e_lamps[8:6]);
        check("s", s, e_lamps[5:3]);
        check("b", b, e_lamps[2:0]);
        check("fault", fault, e_fault);
        check("fault_code", fault_code, m_code);
        cyc++;
    endtask

    task automatic set_pat(input logic [2:0] a, input logic [2:0] bb, input logic [2:0] c, input logic [2:0] d);
        l_in = a; r_in = bb; s_in = c; b_in = d;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step((cyc % 4) == 0, 1'b0, 1'b0);
    endtask

    // Turns every green to yellow so any directed pattern can follow without a green->red jump.
    task automatic yellow_out();
        if (l_in == G) l_in = Y;
        if (r_in == G) r_in = Y;
        if (s_in == G) s_in = Y;
        if (b_in == G) b_in = Y;
        run(1);
    endtask

    int tr_app, tr_left;
    bit tr_yel;

    task automatic traffic_restart();
        tr_app = 0; tr_yel = 0; tr_left = 2;
    endtask

    // Well-behaved controller: one approach at a time, green -> yellow -> next approach.
    task automatic traffic(input int n);
        logic [11:0] pat;
        for (int i = 0; i < n; i++) begin
            if (tr_left == 0) begin
                if (!tr_yel) tr_yel = 1;
                else begin tr_yel = 0; tr_app = (tr_app + 1) % 4; end
                tr_left = $urandom_range(2, 8);
            end
            tr_left--;
            pat = {R, R, R, R};
            pat[3*(3-tr_app) +: 3] = tr_yel ? Y : G;
            {l_in, r_in, s_in, b_in} = pat;
            run(1);
        end
    endtask

    task automatic noise(input int n);
        logic [11:0] pat;
        int k;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    pat = {R, R, R, R};
                    k = $urandom_range(0, 3);
                    pat[3*k +: 3] = ($urandom_range(0, 1) == 1) ? G : Y;
                end else begin
                    pat = 12'($urandom);
                end
                {l_in, r_in, s_in, b_in} = pat;
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; clr_fault = 1'b0;
        set_pat(G, Y, R, R);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("reset_l", l, R);
        check("reset_fault", fault, 1'b0);
        check("reset_code", fault_code, 3'd0);

        // Left-green pattern held: all red for two ticks, then pass-through.
        run(12);
        check("pass_l", l, G);
        check("pass_r", r, Y);
        traffic_restart();
        traffic(60);

        // Conflict for 3 cycles is filtered out; 4 cycles declares code 1.
        yellow_out();
        set_pat(G, R, G, R);
        run(3);
        set_pat(G, R, Y, R);
        run(1);
        check("short_conflict_fault", fault, 1'b0);
        set_pat(G, R, G, R);
        run(4);
        check("conflict_fault", fault, 1'b1);
        check("conflict_code", fault_code, 3'd1);
        run(14);
        set_pat(G, R, Y, R);
        step(1'b0, 1'b1, 1'b0);
        check("clear_fault", fault, 1'b0);
        traffic_restart();
        traffic(40);

        // Conflict plus invalid: conflict wins; clear refused while invalid persists.
        yellow_out();
        set_pat(G, 3'b011, G, R);
        run(5);
        check("prio_code", fault_code, 3'd1);
        step(1'b0, 1'b1, 1'b0);
        check("clr_refused", fault, 1'b1);
        set_pat(G, R, Y, R);
        step(1'b0, 1'b1, 1'b0);
        check("clr_accepted", fault, 1'b0);
        traffic_restart();
        traffic(40);

        // Frozen inputs trip the watchdog; clear then all-red before pass-through.
        yellow_out();
        set_pat(Y, R, R, R);
        run(72);
        check("wdog_code", fault_code, 3'd3);
        set_pat(G, R, R, R);
        step(1'b0, 1'b1, 1'b0);
        check("wdog_clear", fault, 1'b0);
        check("wdog_allred", l, R);
        traffic_restart();
        traffic(40);

        // Green straight to red on the left approach.
        yellow_out();
        set_pat(G, R, R, R);
        run(2);
        set_pat(R, R, R, R);
        run(4);
`ifdef YELLOW_CHECK_EN
        check("skip_code", fault_code, 3'd4);
        set_pat(Y, R, R, R);
        step(1'b0, 1'b1, 1'b0);
        check("skip_clear", fault, 1'b0);
`else
        check("skip_ignored", fault, 1'b0);
        check("skip_pass", l, R);
`endif
        traffic_restart();
        traffic(40);

        // Reset in FLASH restarts without operator action.
        yellow_out();
        set_pat(G, Y, G, R);
        run(6);
        check("pre_rst_fault", fault, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("rst_flash_l", l, R);
        check("rst_flash_code", fault_code, 3'd0);
        check("rst_flash_fault", fault, 1'b0);
        traffic_restart();
        traffic(40);
        check("resume_fault", fault, 1'b0);

        noise(1500);
        traffic_restart();
        step(1'b0, 1'b0, 1'b1);
        traffic(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
